// File: rtl/adder_fp_unit.sv
// adder_fp_unit: multi-cycle IEEE-754 binary32 adder/subtractor.
//
// Computes Y = A + B (op=0) or Y = A - B (op=1). Operands are captured on
// start in IDLE, walk through UNPACK/ALIGN/ADD/NORM, and the result is loaded
// into Y on entry to DONE, where ready pulses for one cycle. Y then holds
// until the next DONE. Denormal inputs are flushed to zero, and results whose
// exponent underflows are flushed to a signed zero.
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   start  in  1   request, sampled only in IDLE
//   op     in  1   0 = add, 1 = subtract
//   A, B   in  32  operands, captured with start
//   busy   out 1   high in UNPACK, ALIGN, ADD and NORM
//   ready  out 1   one-cycle pulse in DONE; Y valid
//   Y      out 32  result, held between operations
//
// Build option: define ADDER_FP_ROUND_EN for round-to-nearest-even.
// Without it the result is truncated toward zero. Latency is the same in both
// builds.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; operands are captured when it is seen
// UNPACK | split fields, flush denormals, resolve NaN/Inf cases
// ALIGN  | order by magnitude and shift the smaller operand into G/R/S
// ADD    | add or subtract the aligned significands
// NORM   | normalize, round and pack; Y is loaded on leaving this state
// DONE   | ready pulse, then back to IDLE
module adder_fp_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        ready,
    output logic [31:0] Y
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t state, state_next;

    logic [31:0] a_q, b_q;
    logic        op_q;

    logic        sign_a_q, sign_b_q;
    logic [7:0]  exp_a_q, exp_b_q;
    logic [23:0] sig_a_q, sig_b_q;
    logic        special_q;
    logic [31:0] special_val_q;

    logic        sign_l_q, sign_s_q;
    logic [7:0]  exp_l_q;
    logic [26:0] ext_l_q, ext_s_q;

    logic        sign_r_q;
    logic [27:0] sum_q;

    // UNPACK combinational signals
    logic        u_sign_b;
    logic        u_nan, u_inf_a, u_inf_b, u_special;
    logic [31:0] u_special_val;
    logic [23:0] u_sig_a, u_sig_b;

    // ALIGN combinational signals
    logic        l_is_a;
    logic [7:0]  exp_s, exp_diff;
    logic [23:0] sig_l, sig_s;
    logic [4:0]  shift_amt;
    logic [53:0] shifted;
    logic [26:0] aligned;

    // NORM combinational signals
    logic [4:0]        lzc;
    logic [26:0]       n_ext;
    logic signed [9:0] n_exp, exp_f;
    logic [23:0]       mant_f;
    logic [31:0]       result;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_UNPACK;
            S_UNPACK: begin busy = 1'b1; state_next = S_ALIGN; end
            S_ALIGN:  begin busy = 1'b1; state_next = S_ADD;   end
            S_ADD:    begin busy = 1'b1; state_next = S_NORM;  end
            S_NORM:   begin busy = 1'b1; state_next = S_DONE;  end
            S_DONE:   begin ready = 1'b1; state_next = S_IDLE; end
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // UNPACK
    // ---------------------------------------------------------------
    always_comb begin
        u_sign_b      = b_q[31] ^ op_q;
        u_nan         = (a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0) ||
                        (b_q[30:23] == 8'hFF && b_q[22:0] != 23'd0);
        u_inf_a       = a_q[30:23] == 8'hFF && a_q[22:0] == 23'd0;
        u_inf_b       = b_q[30:23] == 8'hFF && b_q[22:0] == 23'd0;
        u_sig_a       = (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
        u_sig_b       = (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        u_special     = 1'b1;
        u_special_val = QNAN;
        if (u_nan)
            u_special_val = QNAN;
        else if (u_inf_a && u_inf_b)
            u_special_val = (a_q[31] == u_sign_b) ? {a_q[31], 8'hFF, 23'd0} : QNAN;
        else if (u_inf_a)
            u_special_val = {a_q[31], 8'hFF, 23'd0};
        else if (u_inf_b)
            u_special_val = {u_sign_b, 8'hFF, 23'd0};
        else
            u_special = 1'b0;
    end

    // ---------------------------------------------------------------
    // ALIGN
    // ---------------------------------------------------------------
    always_comb begin
        // Flushed operands carry exponent 0 and significand 0, so they sort
        // below every normal number.
        l_is_a    = {exp_a_q, sig_a_q} >= {exp_b_q, sig_b_q};
        sig_l     = l_is_a ? sig_a_q : sig_b_q;
        sig_s     = l_is_a ? sig_b_q : sig_a_q;
        exp_s     = l_is_a ? exp_b_q : exp_a_q;
        exp_diff  = (l_is_a ? exp_a_q : exp_b_q) - exp_s;
        // Beyond 27 nothing of the smaller operand reaches the G/R/S window
        // except through sticky, so the shifter width can be clamped.
        shift_amt = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        shifted   = {sig_s, 3'b000, 27'd0} >> shift_amt;
        aligned   = {shifted[53:28], shifted[27] | (|shifted[26:0])};
    end

    // ---------------------------------------------------------------
    // NORM: normalize, round, pack
    // ---------------------------------------------------------------
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i <= 26; i++)
            if (sum_q[i]) lzc = 5'(26 - i);

        if (sum_q[27]) begin
            n_ext = {sum_q[27:2], sum_q[1] | sum_q[0]};
            n_exp = $signed({2'b00, exp_l_q}) + 10'sd1;
        end else begin
            n_ext = sum_q[26:0] << lzc;
            n_exp = $signed({2'b00, exp_l_q}) - $signed({5'd0, lzc});
        end

`ifdef ADDER_FP_ROUND_EN
        begin
            logic        round_up;
            logic [24:0] mant_r;
            round_up = n_ext[2] & (n_ext[1] | n_ext[0] | n_ext[3]);
            mant_r   = {1'b0, n_ext[26:3]} + {24'd0, round_up};
            if (mant_r[24]) begin
                mant_f = mant_r[24:1];
                exp_f  = n_exp + 10'sd1;
            end else begin
                mant_f = mant_r[23:0];
                exp_f  = n_exp;
            end
        end
`else
        mant_f = n_ext[26:3];
        exp_f  = n_exp;
`endif

        if (special_q)
            result = special_val_q;
        else if (sum_q == 28'd0)
            result = 32'd0;
        else if (exp_f >= 10'sd255)
            result = {sign_r_q, 8'hFF, 23'd0};
        else if (exp_f <= 10'sd0)
            result = {sign_r_q, 31'd0};
        else
            result = {sign_r_q, exp_f[7:0], mant_f[22:0]};
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            op_q          <= 1'b0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            exp_a_q       <= 8'd0;
            exp_b_q       <= 8'd0;
            sig_a_q       <= 24'd0;
            sig_b_q       <= 24'd0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            sign_l_q      <= 1'b0;
            sign_s_q      <= 1'b0;
            exp_l_q       <= 8'd0;
            ext_l_q       <= 27'd0;
            ext_s_q       <= 27'd0;
            sign_r_q      <= 1'b0;
            sum_q         <= 28'd0;
            Y             <= 32'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q  <= A;
                    b_q  <= B;
                    op_q <= op;
                end
                S_UNPACK: begin
                    sign_a_q      <= a_q[31];
                    sign_b_q      <= u_sign_b;
                    exp_a_q       <= a_q[30:23];
                    exp_b_q       <= b_q[30:23];
                    sig_a_q       <= u_sig_a;
                    sig_b_q       <= u_sig_b;
                    special_q     <= u_special;
                    special_val_q <= u_special_val;
                end
                S_ALIGN: begin
                    sign_l_q <= l_is_a ? sign_a_q : sign_b_q;
                    sign_s_q <= l_is_a ? sign_b_q : sign_a_q;
                    exp_l_q  <= l_is_a ? exp_a_q : exp_b_q;
                    ext_l_q  <= {sig_l, 3'b000};
                    ext_s_q  <= aligned;
                end
                S_ADD: begin
                    sign_r_q <= sign_l_q;
                    sum_q    <= (sign_l_q == sign_s_q) ? {1'b0, ext_l_q} + {1'b0, ext_s_q}
                                                       : {1'b0, ext_l_q} - {1'b0, ext_s_q};
                end
                S_NORM: Y <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_fp_unit.sv
module tb_adder_fp_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, ready;
    logic [31:0] Y;

    adder_fp_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .ready(ready), .Y(Y)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held_y = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: form the exact sum as a wide integer (smaller operands far
    // below the larger one only contribute a fraction of one unit), then round
    // that exact value to 24 significant bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic        sa, sb, sl, ss, tiny;
        int          ea, eb, el, es, d, p, sh, e;
        logic [79:0] ma, mb, ml, ms, mag, kept, rem, half;
        sa = a[31];
        sb = b[31] ^ o;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
        if (ea == 255) return {sa, 8'hFF, 23'd0};
        if (eb == 255) return {sb, 8'hFF, 23'd0};
        ma = (ea == 0) ? 80'd0 : {56'd0, 1'b1, a[22:0]};
        mb = (eb == 0) ? 80'd0 : {56'd0, 1'b1, b[22:0]};
        if (ma == 0 && mb == 0) return 32'd0;
        if (mb == 0 || (ma != 0 && (ea > eb || (ea == eb && ma >= mb)))) begin
            sl = sa; ml = ma; el = ea; ss = sb; ms = mb; es = eb;
        end else begin
            sl = sb; ml = mb; el = eb; ss = sa; ms = ma; es = ea;
        end
        tiny = 1'b0;
        d = el - es;
        if (ms == 0)       mag = ml << 40;
        else if (d <= 40)  mag = (sl == ss) ? (ml << 40) + (ms << (40 - d)) : (ml << 40) - (ms << (40 - d));
        else begin
            tiny = 1'b1;
            mag  = (sl == ss) ? (ml << 40) : (ml << 40) - 80'd1;
        end
        if (mag == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 80; i++) if (mag[i]) p = i;
        sh   = p - 23;
        kept = mag >> sh;
        rem  = mag - (kept << sh);
        half = 80'd1 << (sh - 1);
        e    = sh + el - 40;
`ifdef ADDER_FP_ROUND_EN
        if (rem > half || (rem == half && (tiny || kept[0]))) kept = kept + 80'd1;
        if (kept == (80'd1 << 24)) begin
            kept = kept >> 1;
            e    = e + 1;
        end
`endif
        if (e >= 255) return {sl, 8'hFF, 23'd0};
        if (e <= 0)   return {sl, 31'd0};
        return {sl, e[7:0], kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand(input int near_exp);
        logic [31:0] v;
        int          k, e;
        v = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0)       v[30:0] = 31'd0;
        else if (k == 1)  v[30:23] = 8'd0;
        else if (k == 2)  v[30:0] = {8'hFF, 23'd0};
        else if (k == 3)  v[30:22] = 9'h1FF;
        else if (k == 4)  v[30:23] = ($urandom_range(0, 1) == 1) ? 8'd254 : 8'd1;
        else if (k <= 12) begin
            e = near_exp + int'($urandom_range(0, 4)) - 2;
            if (e < 1)   e = 1;
            if (e > 254) e = 254;
            v[30:23] = e[7:0];
        end else begin
            e = int'($urandom_range(1, 254));
            v[30:23] = e[7:0];
        end
        return v;
    endfunction

    // Scoreboard monitor: pops an expectation on every ready pulse and checks
    // that Y does not move between pulses.
    always @(negedge clk) begin
        if (!rst_n) held_y = 32'd0;
        else if (ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: Y=%08h with no pending operation", Y);
            end else check("result", Y, exp_q.pop_front());
            held_y = Y;
        end else check("y_hold", Y, held_y);
    end

    task automatic wait_idle();
        int g = 0;
        while ((busy || ready) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (busy || ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_wait: busy=%0d ready=%0d, required both 0", busy, ready);
        end
    endtask

    // Issue one operation and check the handshake timing; operands are
    // scrambled while busy to confirm they are not re-sampled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] expected);
        wait_idle();
        A = a; B = b; op = o; start = 1'b1;
        exp_q.push_back(expected);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("busy_in_flight", {31'd0, busy}, 32'd1);
            check("ready_in_flight", {31'd0, ready}, 32'd0);
            A = $urandom; B = $urandom; op = 1'($urandom);
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            @(negedge clk);
        end
        check("busy_done", {31'd0, busy}, 32'd0);
        check("ready_done", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        ro;
        int          seen, c1, gap, g;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_y", Y, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h42371EB8, 32'h4131999A, 1'b0, 32'h4263851E);
`ifdef ADDER_FP_ROUND_EN
        issue(32'h42371EB8, 32'h4131999A, 1'b1, 32'h420AB852);
`else
        issue(32'h42371EB8, 32'h4131999A, 1'b1, 32'h420AB851);
`endif
        issue(32'h404CCCCD, 32'h404CCCCD, 1'b0, 32'h40CCCCCD);
        issue(32'h404CCCCD, 32'h404CCCCD, 1'b1, 32'h00000000);
        issue(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
        issue(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
        issue(32'h80000000, 32'h00000000, 1'b1, 32'h00000000);

        // start held high: second operation only after IDLE
        wait_idle();
        A = 32'h3FC00000; B = 32'h40200000; op = 1'b0; start = 1'b1;
        exp_q.push_back(32'h40800000);
        exp_q.push_back(32'h40800000);
        seen = 0; c1 = 0; gap = -1; g = 0;
        while (seen < 2 && g < 40) begin
            @(negedge clk);
            g++;
            if (ready) begin
                seen++;
                if (seen == 1) c1 = g;
                else gap = g - c1 - 1;
            end
        end
        start = 1'b0;
        check("held_start_results", seen, 32'd2);
        check("held_start_gap", gap, 32'd5);

        // reset during ALIGN aborts the operation
        wait_idle();
        @(negedge clk);
        A = 32'h40400000; B = 32'h3F800000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_y", Y, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);

        for (int n = 0; n < 300; n++) begin
            ra = rand_operand(int'($urandom_range(1, 254)));
            rb = rand_operand(int'(ra[30:23]));
            if ($urandom_range(0, 9) == 0) rb = {1'($urandom), ra[30:0]};
            ro = 1'($urandom);
            issue(ra, rb, ro, ref_add(ra, rb, ro));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("pending_left", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
